teeter_ball_ctrl: RTL and testbench
===================================

Name: teeter_ball_ctrl

Overview:
- Game-level sequencer for the ball X-position integrator (32-bit fixed-point position register, preset/accumulate inputs).
- Generates the physics tick and drives the integrator's three preset strobes (centre / left end / right end).
- Integrates board tilt into a saturated signed velocity and detects the ball rolling off either end.
- Sits between the input/tilt logic and the position integrator; its state output feeds display/score logic.

Parameters:
- TICK_DIV, 50000, clock cycles per physics tick (>=2).
- SERVE_DELAY, 16, ticks the ball is held at centre before rolling (>=1).
- VEL_MAX, 64, velocity saturation magnitude in fixed-point units (position LSB<<4).
- POS_MIN, 0, lowest legal integer position (signed).
- POS_MAX, 100, highest legal integer position (signed).
- TILT_W, 4, width of the signed tilt input.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  start/restart request, sampled in IDLE and OVER.
- i_tilt  in  TILT_W  signed acceleration per tick (two's complement).
- i_pos  in  32  signed integer ball position from the integrator.
- o_calc_time  out  1  one-cycle accumulate strobe to the integrator.
- o_velocity  out  32  signed velocity to the integrator, fixed-point.
- o_rst0  out  1  preset-to-centre strobe.
- o_rst1  out  1  preset-to-left-end strobe.
- o_rst2  out  1  preset-to-right-end strobe.
- o_state  out  2  0=IDLE 1=SERVE 2=ROLL 3=OVER.
- o_fell_left  out  1  ball left via the POS_MIN side.
- o_fell_right  out  1  ball left via the POS_MAX side.

Behaviour:
- Reset (i_rst_n=0 at posedge): state IDLE, tick counter 0, serve counter 0, velocity 0, o_calc_time/o_rst1/o_rst2/o_fell_* 0. Reset mid-game aborts immediately; no pending strobes survive.
- o_rst0 is a decode of state: 1 in IDLE and SERVE (ball held at centre), else 0. All other outputs are registered.
- Tick counter: counts 0..TICK_DIV-1, wraps. tick=1 when count==TICK_DIV-1. Cleared to 0 on every transition into SERVE.
- IDLE: velocity 0. i_start=1 -> SERVE, serve counter cleared.
- SERVE: velocity 0, no calc strobes. Serve counter increments per tick; on the tick that brings it to SERVE_DELAY -> ROLL. i_start ignored.
- ROLL, bounds check every cycle, priority over tick:
  - i_pos < POS_MIN (signed): next cycle o_rst1=1 for exactly one cycle, o_fell_left=1, velocity 0, -> OVER.
  - i_pos > POS_MAX: same, but o_rst2 and o_fell_right.
  - An out-of-bounds cycle that coincides with a tick produces no o_calc_time and no velocity update.
- ROLL, in bounds on a tick: o_calc_time=1 next cycle for one cycle. o_velocity during that strobe is the pre-update value. The velocity register then becomes sat(v + sext(i_tilt)), clamped to [-VEL_MAX, +VEL_MAX]; the update is applied in the same edge as the strobe. Arithmetic is 33-bit signed before clamping.
- OVER: velocity 0, no strobes. Fall flags held. i_start=1 -> SERVE with flags cleared.
- i_start is level-sampled; holding it high in OVER restarts exactly once, since SERVE ignores it.

Optional Feature:
- Macro TEETER_FRICTION_EN.
- Defined: on a ROLL tick with i_tilt==0, velocity magnitude decreases by 1 toward 0; 0 stays 0. Non-zero tilt behaves as normal.
- Undefined: i_tilt==0 leaves velocity unchanged.

Test Plan (TICK_DIV=4, SERVE_DELAY=2, VEL_MAX=8):
- Reset, then hold: o_state=0, o_rst0=1, o_velocity=0, no o_calc_time for 20 cycles.
- i_start pulse, i_pos=50 -> o_state=1 for 8 cycles, o_rst0=1, then o_state=2 and o_rst0=0.
- ROLL, i_tilt=+3, i_pos=50 -> o_calc_time every 4 cycles; o_velocity at successive strobes 0,3,6,8,8 (saturated).
- i_tilt=-1 (4'hF) from v=0 -> strobe velocities 0,-1,-2,...; clamps at -8, sign-extended to 32'hFFFFFFF8.
- ROLL, force i_pos=101 on a tick cycle -> no o_calc_time; o_rst2 one cycle; o_fell_right=1; o_state=3. Then i_start -> o_state=1, flags 0, o_rst0=1.
- ROLL, i_pos=-1 -> o_rst1 pulse, o_fell_left=1. Then i_rst_n=0 one cycle mid-ROLL -> IDLE, velocity 0, flags 0. With TEETER_FRICTION_EN and v=5, i_tilt=0 -> strobes 5,4,3,2,1,0,0.

Source files
------------

// File: rtl/teeter_ball_ctrl.sv
// teeter_ball_ctrl: game-level sequencer for the ball X-position integrator.
//
// Generates the physics tick, drives the integrator preset strobes
// (centre / left end / right end) and the accumulate strobe, integrates the
// board tilt into a saturated signed velocity and detects the ball leaving
// the board on either end.
//
// Build option:
//   TEETER_FRICTION_EN - when defined, a ROLL tick with zero tilt bleeds one
//                        unit of velocity magnitude toward zero. When left
//                        undefined, zero tilt leaves the velocity unchanged.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for i_start, ball held at centre, velocity 0
// SERVE | ball held at centre for SERVE_DELAY ticks, i_start ignored
// ROLL  | velocity integrates tilt each tick, bounds checked every cycle
// OVER  | ball fell off, fall flag held, waiting for i_start to re-serve

module teeter_ball_ctrl #(
    parameter int TICK_DIV    = 50000,
    parameter int SERVE_DELAY = 16,
    parameter int VEL_MAX     = 64,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 100,
    parameter int TILT_W      = 4
) (
    input  logic              CLK,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [TILT_W-1:0] i_tilt,
    input  logic [31:0]       i_pos,
    output logic              o_calc_time,
    output logic [31:0]       o_velocity,
    output logic              o_rst0,
    output logic              o_rst1,
    output logic              o_rst2,
    output logic [1:0]        o_state,
    output logic              o_fell_left,
    output logic              o_fell_right
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_ROLL  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int TICK_W  = $clog2(TICK_DIV);
    localparam int SERVE_W = $clog2(SERVE_DELAY + 1);

    localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [SERVE_W-1:0]  SERVE_LAST = SERVE_W'(SERVE_DELAY - 1);
    localparam logic signed [31:0]  POS_MIN_S  = 32'(POS_MIN);
    localparam logic signed [31:0]  POS_MAX_S  = 32'(POS_MAX);
    localparam logic signed [32:0]  VEL_HI     = 33'(VEL_MAX);
    localparam logic signed [32:0]  VEL_LO     = 33'(-VEL_MAX);

    state_t                    state;
    logic [TICK_W-1:0]         tick_cnt;
    logic [SERVE_W-1:0]        serve_cnt;
    logic signed [31:0]        vel;
    logic [TILT_W-1:0]         tilt_q;

    logic                      tick;
    logic                      start_req;
    logic                      pos_lo;
    logic                      pos_hi;
    logic signed [32:0]        vel_sum;
    logic signed [31:0]        vel_sat;
    logic signed [31:0]        vel_next;

    assign tick      = (tick_cnt == TICK_LAST);
    assign start_req = i_start && ((state == ST_IDLE) || (state == ST_OVER));
    assign pos_lo    = ($signed(i_pos) < POS_MIN_S);
    assign pos_hi    = ($signed(i_pos) > POS_MAX_S);

    assign o_velocity = vel;
    assign o_state    = state;
    assign o_rst0     = (state == ST_IDLE) || (state == ST_SERVE);

    // Velocity update candidate: tilt captured at the tick edge, summed at 33 bits, then clamped.
    always_comb begin
        vel_sum = {vel[31], vel} + {{(33 - TILT_W){tilt_q[TILT_W-1]}}, tilt_q};
        if (vel_sum > VEL_HI) begin
            vel_sat = VEL_HI[31:0];
        end else if (vel_sum < VEL_LO) begin
            vel_sat = VEL_LO[31:0];
        end else begin
            vel_sat = vel_sum[31:0];
        end
`ifdef TEETER_FRICTION_EN
        if (tilt_q == '0) begin
            if (vel > 0) begin
                vel_next = vel - 32'sd1;
            end else if (vel < 0) begin
                vel_next = vel + 32'sd1;
            end else begin
                vel_next = vel;
            end
        end else begin
            vel_next = vel_sat;
        end
`else
        vel_next = vel_sat;
`endif
    end

    // Physics tick divider; restarts on every entry into SERVE so the serve hold is exact.
    always_ff @(posedge CLK) begin
        if (!i_rst_n) begin
            tick_cnt <= '0;
        end else if (start_req || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Game FSM with registered strobes, fall flags and velocity.
    // The accumulate strobe is raised on the edge after a tick; the integrator
    // samples it on the following edge using the old velocity, and that same
    // edge commits the new velocity.
    always_ff @(posedge CLK) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            serve_cnt    <= '0;
            vel          <= '0;
            tilt_q       <= '0;
            o_calc_time  <= 1'b0;
            o_rst1       <= 1'b0;
            o_rst2       <= 1'b0;
            o_fell_left  <= 1'b0;
            o_fell_right <= 1'b0;
        end else begin
            o_calc_time <= 1'b0;
            o_rst1      <= 1'b0;
            o_rst2      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    vel <= '0;
                    if (i_start) begin
                        state     <= ST_SERVE;
                        serve_cnt <= '0;
                    end
                end

                ST_SERVE: begin
                    vel <= '0;
                    if (tick) begin
                        if (serve_cnt == SERVE_LAST) begin
                            state     <= ST_ROLL;
                            serve_cnt <= '0;
                        end else begin
                            serve_cnt <= serve_cnt + 1'b1;
                        end
                    end
                end

                ST_ROLL: begin
                    if (pos_lo) begin
                        o_rst1      <= 1'b1;
                        o_fell_left <= 1'b1;
                        vel         <= '0;
                        state       <= ST_OVER;
                    end else if (pos_hi) begin
                        o_rst2       <= 1'b1;
                        o_fell_right <= 1'b1;
                        vel          <= '0;
                        state        <= ST_OVER;
                    end else begin
                        if (o_calc_time) begin
                            vel <= vel_next;
                        end
                        if (tick) begin
                            o_calc_time <= 1'b1;
                            tilt_q      <= i_tilt;
                        end
                    end
                end

                ST_OVER: begin
                    vel <= '0;
                    if (i_start) begin
                        state        <= ST_SERVE;
                        serve_cnt    <= '0;
                        o_fell_left  <= 1'b0;
                        o_fell_right <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    vel   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_teeter_ball_ctrl.sv
// Directed bench for teeter_ball_ctrl with TICK_DIV=4, SERVE_DELAY=2, VEL_MAX=8.
module tb_teeter_ball_ctrl;

    logic        CLK;
    logic        i_rst_n;
    logic        i_start;
    logic [3:0]  i_tilt;
    logic [31:0] i_pos;
    logic        o_calc_time;
    logic [31:0] o_velocity;
    logic        o_rst0;
    logic        o_rst1;
    logic        o_rst2;
    logic [1:0]  o_state;
    logic        o_fell_left;
    logic        o_fell_right;

    int n_vec = 0;
    int n_err = 0;

    teeter_ball_ctrl #(
        .TICK_DIV    (4),
        .SERVE_DELAY (2),
        .VEL_MAX     (8),
        .POS_MIN     (0),
        .POS_MAX     (100),
        .TILT_W      (4)
    ) dut (
        .CLK          (CLK),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_tilt       (i_tilt),
        .i_pos        (i_pos),
        .o_calc_time  (o_calc_time),
        .o_velocity   (o_velocity),
        .o_rst0       (o_rst0),
        .o_rst1       (o_rst1),
        .o_rst2       (o_rst2),
        .o_state      (o_state),
        .o_fell_left  (o_fell_left),
        .o_fell_right (o_fell_right)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Steps until the ball leaves SERVE; n counts SERVE cycles including the current one.
    task automatic wait_roll(output int n);
        n = 0;
        while (o_state == 2'd1 && n < 30) begin
            n++;
            step();
        end
    endtask

    // Steps until an accumulate strobe is seen; gap = cycles stepped (0 on timeout).
    task automatic wait_strobe(output logic [31:0] v, output int gap);
        int k;
        k = 0;
        v = 'x;
        gap = 0;
        while (k < 20) begin
            step();
            k++;
            if (o_calc_time === 1'b1) begin
                v = o_velocity;
                gap = k;
                break;
            end
        end
    endtask

    initial begin
        int          n;
        int          gap;
        int          calc_seen;
        int          e;
        logic [31:0] v;

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_tilt  = 4'd0;
        i_pos   = 32'd50;
        step();
        step();
        i_rst_n = 1'b1;

        // Reset state and IDLE hold
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_rst0", 32'(o_rst0), 32'd1);
        chk("rst_vel", o_velocity, 32'd0);
        chk("rst_calc", 32'(o_calc_time), 32'd0);
        chk("rst_rst12", {30'd0, o_rst1, o_rst2}, 32'd0);
        chk("rst_fell", {30'd0, o_fell_left, o_fell_right}, 32'd0);
        calc_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_calc_time !== 1'b0 || o_state !== 2'd0) calc_seen++;
        end
        chk("idle_hold", 32'(calc_seen), 32'd0);

        // Serve: 8 cycles with the ball held at centre
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("serve_state", 32'(o_state), 32'd1);
        chk("serve_rst0", 32'(o_rst0), 32'd1);
        wait_roll(n);
        chk("serve_len", 32'(n), 32'd8);
        chk("roll_state", 32'(o_state), 32'd2);
        chk("roll_rst0", 32'(o_rst0), 32'd0);

        // Positive tilt saturates at +8
        i_tilt = 4'd3;
        for (int k = 0; k < 5; k++) begin
            wait_strobe(v, gap);
            e = (3 * k > 8) ? 8 : 3 * k;
            chk($sformatf("pos_vel_%0d", k), v, 32'(e));
            chk($sformatf("pos_gap_%0d", k), 32'(gap), 32'd4);
        end

        // Right fall on a tick cycle
        step();
        step();
        step();
        i_pos = 32'd101;
        step();
        chk("right_calc", 32'(o_calc_time), 32'd0);
        chk("right_rst2", 32'(o_rst2), 32'd1);
        chk("right_rst1", 32'(o_rst1), 32'd0);
        chk("right_fell", {30'd0, o_fell_left, o_fell_right}, 32'd1);
        chk("right_state", 32'(o_state), 32'd3);
        chk("right_vel", o_velocity, 32'd0);
        step();
        chk("right_rst2_off", 32'(o_rst2), 32'd0);
        chk("right_fell_hold", 32'(o_fell_right), 32'd1);

        // Restart with i_start held high: exactly one serve
        i_pos   = 32'd50;
        i_start = 1'b1;
        step();
        chk("restart_state", 32'(o_state), 32'd1);
        chk("restart_fell", {30'd0, o_fell_left, o_fell_right}, 32'd0);
        chk("restart_rst0", 32'(o_rst0), 32'd1);
        wait_roll(n);
        chk("restart_serve_len", 32'(n), 32'd8);
        chk("restart_roll", 32'(o_state), 32'd2);
        i_start = 1'b0;

        // Negative tilt saturates at -8
        i_tilt = 4'hF;
        for (int k = 0; k < 10; k++) begin
            wait_strobe(v, gap);
            e = (k > 8) ? -8 : -k;
            chk($sformatf("neg_vel_%0d", k), v, 32'(e));
        end
        chk("neg_gap", 32'(gap), 32'd4);

        // Left fall
        i_pos = 32'hFFFF_FFFF;
        step();
        chk("left_rst1", 32'(o_rst1), 32'd1);
        chk("left_rst2", 32'(o_rst2), 32'd0);
        chk("left_fell", {30'd0, o_fell_left, o_fell_right}, 32'd2);
        chk("left_state", 32'(o_state), 32'd3);
        chk("left_vel", o_velocity, 32'd0);
        step();
        chk("left_rst1_off", 32'(o_rst1), 32'd0);
        chk("left_over_hold", 32'(o_state), 32'd3);

        // Restart, build v=5, then zero tilt
        i_pos   = 32'd50;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("left_restart_fell", 32'(o_fell_left), 32'd0);
        wait_roll(n);
        chk("serve_len3", 32'(n), 32'd8);
        i_tilt = 4'd5;
        wait_strobe(v, gap);
        chk("fric_first", v, 32'd0);
        i_tilt = 4'd0;
        for (int k = 0; k < 7; k++) begin
            wait_strobe(v, gap);
`ifdef TEETER_FRICTION_EN
            e = (5 - k > 0) ? 5 - k : 0;
`else
            e = 5;
`endif
            chk($sformatf("zero_tilt_vel_%0d", k), v, 32'(e));
        end

        // Reset mid-ROLL on a tick cycle kills the pending strobe
        step();
        step();
        step();
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        chk("mid_rst_state", 32'(o_state), 32'd0);
        chk("mid_rst_vel", o_velocity, 32'd0);
        chk("mid_rst_calc", 32'(o_calc_time), 32'd0);
        chk("mid_rst_fell", {30'd0, o_fell_left, o_fell_right}, 32'd0);
        chk("mid_rst_rst12", {30'd0, o_rst1, o_rst2}, 32'd0);
        chk("mid_rst_rst0", 32'(o_rst0), 32'd1);
        step();
        chk("post_rst_calc", 32'(o_calc_time), 32'd0);
        chk("post_rst_state", 32'(o_state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
